housekeeping_spi_master: RTL and testbench

- SPI initiator that drives the housekeeping SPI slave protocol from the management/test side. Mode 0: SCK idles low, data changes on the falling edge, data is sampled on the rising edge; MSB first.
- Frame: command byte, then address byte, then data bytes; CSB is held low for the whole frame.
- Used by the SoC-level bench harness and by the debug bridge to read/write housekeeping registers. Pairs directly with housekeeping_spi.

---
 rtl/hkspi_pkg.sv | 37 +++
 rtl/hkspi_clkgen.sv | 49 ++++
 rtl/housekeeping_spi_master.sv | 220 ++++++++++++++++++++++
 tb/tb_housekeeping_spi_master.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hkspi_pkg.sv
// hkspi_pkg: shared definitions for housekeeping_spi_master.
//   - hk_state_t      : frame sequencer state encoding
//   - CMD_*           : bit positions inside the command byte
//   - PASS_*_OP       : pass-through opcodes (used with HKSPI_MASTER_PASSTHRU_EN)
//   - make_cmd()      : builds {wr, rd, nbytes, 3'b000}
package hkspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_PASS,
        ST_HOLD,
        ST_GAP
    } hk_state_t;

    localparam int CMD_WR_BIT = 7;
    localparam int CMD_RD_BIT = 6;
    localparam int CMD_NB_MSB = 5;
    localparam int CMD_NB_LSB = 3;

    localparam logic [7:0] PASS_MGMT_OP = 8'hC4;
    localparam logic [7:0] PASS_USER_OP = 8'hC2;

    function automatic logic [7:0] make_cmd(input logic wr, input logic rd,
                                            input logic [2:0] nb);
        logic [7:0] c;
        c = 8'h00;
        c[CMD_WR_BIT] = wr;
        c[CMD_RD_BIT] = rd;
        c[CMD_NB_MSB:CMD_NB_LSB] = nb;
        return c;
    endfunction

endpackage

// File: rtl/hkspi_clkgen.sv
// hkspi_clkgen: SCK half-period timer for housekeeping_spi_master.
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   en          : counter runs; when low the counter reloads and SCK is forced low
//   run         : SCK toggles on each terminal count (low = plain CLK_DIV timer)
//   stall       : freeze the counter (SCK holds its level)
//   tick        : single-cycle terminal-count strobe
//   rise, fall  : single-cycle strobes, coincident with the edge that moves sck
//   sck         : registered SPI clock level
module hkspi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic run,
    input  logic stall,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic sck
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    assign tick = en && !stall && (cnt == 8'd0);
    assign rise = tick && run && !sck;
    assign fall = tick && run && sck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= RELOAD;
            sck <= 1'b0;
        end else if (!stall) begin
            if (cnt == 8'd0) begin
                cnt <= RELOAD;
                if (run) sck <= ~sck;
            end else begin
                cnt <= cnt - 8'd1;
            end
        end
    end

endmodule

// File: rtl/housekeeping_spi_master.sv
// housekeeping_spi_master: mode-0, MSB-first SPI initiator for the
// housekeeping SPI slave. Frame = command byte, address byte, data bytes,
// with CSB low for the whole frame.
// Optional build macro: HKSPI_MASTER_PASSTHRU_EN adds passthru[1:0]
// (bit1 mgmt 0xC4, bit0 user 0xC2) and the PASS raw-byte state.
// Ports:
//   wb_clk_i, wb_rstn_i : system clock, async active-low reset
//   start               : frame request, sampled in IDLE only
//   cmd_wr, cmd_rd      : command bits 7 / 6
//   nbytes[2:0]         : 1..7 fixed data bytes, 0 = stream until stop
//   addr[7:0]           : start address
//   stop                : ends a streaming frame after the current byte
//   wdata, wdata_valid  : write byte source; wdata_ack pulses on consume
//   rdata, rdata_valid  : last received data byte, pulse per byte
//   busy, done          : frame in progress / end-of-frame pulse
//   SCK, CSB, SDO, SDI  : SPI pins
//
// state | meaning
// IDLE  | CSB high, waiting for start
// SETUP | CSB low, command MSB on SDO, CLK_DIV cycles before clocking
// CMD   | shift command byte
// ADDR  | shift address byte
// DATA  | shift data bytes until count reached or stop seen
// PASS  | raw pass-through bytes until stop (passthru builds only)
// HOLD  | SCK low for CLK_DIV cycles, then CSB rises and done pulses
// GAP   | CSB high for CLK_DIV cycles with busy still high
module housekeeping_spi_master
    import hkspi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rstn_i,
    input  logic       start,
    input  logic       cmd_wr,
    input  logic       cmd_rd,
    input  logic [2:0] nbytes,
    input  logic [7:0] addr,
    input  logic       stop,
`ifdef HKSPI_MASTER_PASSTHRU_EN
    input  logic [1:0] passthru,
`endif
    input  logic [7:0] wdata,
    input  logic       wdata_valid,
    output logic       wdata_ack,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       busy,
    output logic       done,
    output logic       SCK,
    output logic       CSB,
    output logic       SDO,
    input  logic       SDI
);

    hk_state_t  state, state_nx;

    logic       cmd_wr_q, cmd_rd_q, pass_q;
    logic [2:0] nbytes_q;
    logic [7:0] addr_q;
    logic [7:0] tx_sr;
    logic [6:0] rx_sr;
    logic [2:0] bit_cnt, data_cnt;
    logic       stop_seen, wr_pend, csb_q;
    logic [7:0] cmd_byte;

    logic       clk_en, clk_run, tick, sck_rise, sck_fall, sck;
    logic       byte_end, wr_en, rd_en, stop_any, last_byte, need_wdata;

    hkspi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk   (wb_clk_i),
        .rst_n (wb_rstn_i),
        .en    (clk_en),
        .run   (clk_run),
        .stall (wr_pend),
        .tick  (tick),
        .rise  (sck_rise),
        .fall  (sck_fall),
        .sck   (sck)
    );

    always_comb begin
        cmd_byte = make_cmd(cmd_wr, cmd_rd, nbytes);
`ifdef HKSPI_MASTER_PASSTHRU_EN
        if (passthru[1])      cmd_byte = PASS_MGMT_OP;
        else if (passthru[0]) cmd_byte = PASS_USER_OP;
`endif
    end

    assign clk_en   = (state != ST_IDLE);
    assign clk_run  = state inside {ST_CMD, ST_ADDR, ST_DATA, ST_PASS};
    // bit_cnt wraps to 0 after the 8th rise, so this fall closes a byte
    assign byte_end = sck_fall && (bit_cnt == 3'd0);
    assign wr_en    = cmd_wr_q | pass_q;
    assign rd_en    = cmd_rd_q | pass_q;
    assign stop_any = stop_seen | stop;
    assign last_byte = (nbytes_q == 3'd0) ? stop_any
                                          : ((data_cnt + 3'd1) == nbytes_q);
    assign need_wdata = byte_end && wr_en &&
                        ((state_nx == ST_DATA) || (state_nx == ST_PASS));

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) state <= ST_IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_SETUP;
            ST_SETUP: if (tick) state_nx = ST_CMD;
            ST_CMD:   if (byte_end) state_nx = pass_q ? ST_PASS : ST_ADDR;
            ST_ADDR:  if (byte_end) state_nx = ST_DATA;
            ST_DATA:  if (byte_end && last_byte) state_nx = ST_HOLD;
`ifdef HKSPI_MASTER_PASSTHRU_EN
            ST_PASS:  if (byte_end && stop_any) state_nx = ST_HOLD;
`endif
            ST_HOLD:  if (tick) state_nx = ST_GAP;
            ST_GAP:   if (tick) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

`ifdef HKSPI_MASTER_PASSTHRU_EN
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i)                  pass_q <= 1'b0;
        else if (state == ST_IDLE && start) pass_q <= |passthru;
    end
`else
    assign pass_q = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            cmd_wr_q    <= 1'b0;
            cmd_rd_q    <= 1'b0;
            nbytes_q    <= 3'd0;
            addr_q      <= 8'h00;
            tx_sr       <= 8'h00;
            rx_sr       <= 7'd0;
            bit_cnt     <= 3'd0;
            data_cnt    <= 3'd0;
            stop_seen   <= 1'b0;
            wr_pend     <= 1'b0;
            csb_q       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            wdata_ack   <= 1'b0;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
        end else begin
            wdata_ack   <= 1'b0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;

            if (state == ST_IDLE && start) begin
                cmd_wr_q  <= cmd_wr;
                cmd_rd_q  <= cmd_rd;
                nbytes_q  <= nbytes;
                addr_q    <= addr;
                csb_q     <= 1'b0;
                busy      <= 1'b1;
                bit_cnt   <= 3'd0;
                data_cnt  <= 3'd0;
                stop_seen <= 1'b0;
                wr_pend   <= 1'b0;
            end

            if (sck_rise) begin
                rx_sr   <= {rx_sr[5:0], SDI};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7 && rd_en &&
                    (state == ST_DATA || state == ST_PASS)) begin
                    rdata       <= {rx_sr, SDI};
                    rdata_valid <= 1'b1;
                end
            end

            if (state == ST_IDLE && start) begin
                tx_sr <= cmd_byte;
            end else if (need_wdata) begin
                if (wdata_valid) begin
                    tx_sr     <= wdata;
                    wdata_ack <= 1'b1;
                end else begin
                    // SCK stays low (clkgen stalled) until wdata arrives
                    tx_sr   <= 8'h00;
                    wr_pend <= 1'b1;
                end
            end else if (byte_end) begin
                tx_sr <= (state_nx == ST_ADDR) ? addr_q : 8'h00;
            end else if (sck_fall) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end else if (wr_pend && wdata_valid) begin
                tx_sr     <= wdata;
                wdata_ack <= 1'b1;
                wr_pend   <= 1'b0;
            end

            // stop raised on the closing fall still counts for the byte ending there
            if (byte_end) begin
                stop_seen <= 1'b0;
                if (state == ST_DATA) data_cnt <= data_cnt + 3'd1;
            end else if (state == ST_DATA || state == ST_PASS) begin
                stop_seen <= stop_seen | stop;
            end

            if (state == ST_HOLD && tick) begin
                csb_q <= 1'b1;
                done  <= 1'b1;
            end
            if (state == ST_GAP && tick) busy <= 1'b0;
        end
    end

    assign SCK = sck;
    assign CSB = csb_q;
    assign SDO = tx_sr[7];

endmodule

// File: tb/tb_housekeeping_spi_master.sv
module tb_housekeeping_spi_master;

    localparam int CLK_DIV = 4;

    logic       wb_clk_i = 1'b0;
    logic       wb_rstn_i = 1'b0;
    logic       start = 1'b0, cmd_wr = 1'b0, cmd_rd = 1'b0, stop = 1'b0;
    logic [2:0] nbytes = 3'd0;
    logic [7:0] addr = 8'h00, wdata = 8'h00;
    logic       wdata_valid = 1'b0, SDI = 1'b0;
    logic       wdata_ack, rdata_valid, busy, done, SCK, CSB, SDO;
    logic [7:0] rdata;
`ifdef HKSPI_MASTER_PASSTHRU_EN
    logic [1:0] passthru = 2'b00;
`endif

    housekeeping_spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rstn_i   (wb_rstn_i),
        .start       (start),
        .cmd_wr      (cmd_wr),
        .cmd_rd      (cmd_rd),
        .nbytes      (nbytes),
        .addr        (addr),
        .stop        (stop),
`ifdef HKSPI_MASTER_PASSTHRU_EN
        .passthru    (passthru),
`endif
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_ack   (wdata_ack),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
        .done        (done),
        .SCK         (SCK),
        .CSB         (CSB),
        .SDO         (SDO),
        .SDI         (SDI)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] wbytes [8];
    logic [7:0] sbytes [8];
    logic [7:0] rxb    [16];
    logic [7:0] rvals  [8];
    int rise_cnt, nrx, ack_cnt, rv_cnt, done_cnt, low_max, gap_busy, viol;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic run_frame(input logic wr, input logic rd, input logic [2:0] nb,
                             input logic [7:0] a, input logic [1:0] pt,
                             input int stop_at, input int stall_len,
                             input int abort_at, input bit ign_start);
        int hdr, age, low_run, hold, widx, bi;
        logic sck_p, sdo_p, done_seen, aborted;
        logic [7:0] sr, b;
        rise_cnt = 0; nrx = 0; ack_cnt = 0; rv_cnt = 0; done_cnt = 0;
        low_max = 0; gap_busy = 0; viol = 0;
        age = 0; low_run = 0; hold = 0; widx = 0; sr = 8'h00;
        done_seen = 1'b0; aborted = 1'b0;
        hdr = (pt != 2'b00) ? 8 : 16;
        @(negedge wb_clk_i);
        cmd_wr = wr; cmd_rd = rd; nbytes = nb; addr = a; SDI = 1'b0;
`ifdef HKSPI_MASTER_PASSTHRU_EN
        passthru = pt;
`endif
        wdata = wbytes[0]; wdata_valid = 1'b1; start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        chk("busy_rise", int'(busy), 1);
        chk("csb_fall", int'(CSB), 0);
        sck_p = 1'b0; sdo_p = SDO;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (SDO !== sdo_p) age = 0; else age++;
            sdo_p = SDO;
            if (SCK && !sck_p) begin
                sr = {sr[6:0], SDO};
                rise_cnt++;
                if (age < CLK_DIV || CSB) viol++;
                if (rise_cnt % 8 == 0 && nrx < 16) begin rxb[nrx] = sr; nrx++; end
            end
            if (!SCK && sck_p) begin
                if (rise_cnt >= hdr) begin
                    bi = rise_cnt - hdr;
                    b = sbytes[(bi / 8) % 8];
                    SDI = b[7 - (bi % 8)];
                end else SDI = 1'b0;
            end
            sck_p = SCK;
            if (!CSB && !SCK) low_run++; else low_run = 0;
            if (low_run > low_max) low_max = low_run;
            if (wdata_ack) begin
                ack_cnt++; widx++;
                if (widx == 1 && stall_len > 0) hold = stall_len;
            end
            if (hold > 0) begin wdata_valid = 1'b0; hold--; end
            else wdata_valid = 1'b1;
            wdata = wbytes[widx % 8];
            if (rdata_valid) begin rvals[rv_cnt % 8] = rdata; rv_cnt++; end
            if (done) begin done_cnt++; done_seen = 1'b1; end
            if (done_seen) begin
                if (busy) gap_busy++;
                else break;
            end
            stop = (stop_at > 0 && rise_cnt >= stop_at);
            if (ign_start && rise_cnt >= 20 && rise_cnt < 22) begin
                start = 1'b1; nbytes = 3'd1;
            end else begin
                start = 1'b0; nbytes = nb;
            end
            if (abort_at > 0 && rise_cnt >= abort_at) begin
                #3 wb_rstn_i = 1'b0;
                #1;
                chk("abort_csb", int'(CSB), 1);
                chk("abort_sck", int'(SCK), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_sdo", int'(SDO), 0);
                aborted = 1'b1;
                break;
            end
            @(negedge wb_clk_i);
        end
        if (!done_seen && !aborted) chk("frame_timeout", 0, 1);
        stop = 1'b0; start = 1'b0; wdata_valid = 1'b0; nbytes = nb;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin wbytes[i] = 8'h00; sbytes[i] = 8'h00; end
        repeat (2) @(negedge wb_clk_i);
        chk("rst_csb", int'(CSB), 1);
        chk("rst_sck", int'(SCK), 0);
        chk("rst_sdo", int'(SDO), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_rvalid", int'(rdata_valid), 0);
        chk("rst_wack", int'(wdata_ack), 0);
        wb_rstn_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);

        // single write to 0x08
        wbytes[0] = 8'hA5;
        run_frame(1'b1, 1'b0, 3'd1, 8'h08, 2'b00, 0, 0, 0, 1'b0);
        chk("w1_rises", rise_cnt, 24);
        chk("w1_cmd", int'(rxb[0]), 8'h88);
        chk("w1_addr", int'(rxb[1]), 8'h08);
        chk("w1_data", int'(rxb[2]), 8'hA5);
        chk("w1_ack", ack_cnt, 1);
        chk("w1_done", done_cnt, 1);
        chk("w1_rvalid", rv_cnt, 0);
        chk("w1_low_max", low_max, 2 * CLK_DIV);
        chk("w1_gap", gap_busy, CLK_DIV);
        chk("w1_setup_viol", viol, 0);
        chk("w1_csb_end", int'(CSB), 1);

        // read 3 bytes from 0x01; start and stop pulsed mid-frame must be ignored
        sbytes[0] = 8'h56; sbytes[1] = 8'h04; sbytes[2] = 8'h11;
        run_frame(1'b0, 1'b1, 3'd3, 8'h01, 2'b00, 20, 0, 0, 1'b1);
        chk("r3_rises", rise_cnt, 40);
        chk("r3_cmd", int'(rxb[0]), 8'h58);
        chk("r3_addr", int'(rxb[1]), 8'h01);
        chk("r3_rvalid", rv_cnt, 3);
        chk("r3_rd0", int'(rvals[0]), 8'h56);
        chk("r3_rd1", int'(rvals[1]), 8'h04);
        chk("r3_rd2", int'(rvals[2]), 8'h11);
        chk("r3_ack", ack_cnt, 0);
        chk("r3_done", done_cnt, 1);
        chk("r3_viol", viol, 0);

        // streaming write, stop raised during the 4th data byte
        wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33;
        wbytes[3] = 8'h44; wbytes[4] = 8'h55;
        run_frame(1'b1, 1'b0, 3'd0, 8'h40, 2'b00, 43, 0, 0, 1'b0);
        chk("s_rises", rise_cnt, 48);
        chk("s_cmd", int'(rxb[0]), 8'h80);
        chk("s_d0", int'(rxb[2]), 8'h11);
        chk("s_d3", int'(rxb[5]), 8'h44);
        chk("s_ack", ack_cnt, 4);
        chk("s_done", done_cnt, 1);
        chk("s_csb_end", int'(CSB), 1);

        // wdata_valid withheld before the 2nd data byte
        wbytes[0] = 8'h3C; wbytes[1] = 8'hC3;
        run_frame(1'b1, 1'b0, 3'd2, 8'h10, 2'b00, 0, 84, 0, 1'b0);
        chk("st_rises", rise_cnt, 32);
        chk("st_cmd", int'(rxb[0]), 8'h90);
        chk("st_d0", int'(rxb[2]), 8'h3C);
        chk("st_d1", int'(rxb[3]), 8'hC3);
        chk("st_ack", ack_cnt, 2);
        chk("st_stall_long", int'(low_max >= 20), 1);
        chk("st_viol", viol, 0);

        // reset during the address byte
        wbytes[0] = 8'hEE;
        run_frame(1'b1, 1'b0, 3'd1, 8'h08, 2'b00, 0, 0, 10, 1'b0);
        chk("ab_done", done_cnt, 0);
        repeat (3) @(negedge wb_clk_i);
        chk("ab_done_held", int'(done), 0);
        wb_rstn_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        wbytes[0] = 8'h5A;
        run_frame(1'b1, 1'b0, 3'd1, 8'h20, 2'b00, 0, 0, 0, 1'b0);
        chk("ar_rises", rise_cnt, 24);
        chk("ar_addr", int'(rxb[1]), 8'h20);
        chk("ar_data", int'(rxb[2]), 8'h5A);
        chk("ar_done", done_cnt, 1);

        // streaming with stop already high at data entry: one byte
        wbytes[0] = 8'h77; wbytes[1] = 8'h99;
        run_frame(1'b1, 1'b0, 3'd0, 8'h30, 2'b00, 1, 0, 0, 1'b0);
        chk("se_rises", rise_cnt, 24);
        chk("se_data", int'(rxb[2]), 8'h77);
        chk("se_ack", ack_cnt, 1);

`ifdef HKSPI_MASTER_PASSTHRU_EN
        wbytes[0] = 8'hB1; wbytes[1] = 8'hB2;
        sbytes[0] = 8'hD1; sbytes[1] = 8'hD2;
        run_frame(1'b0, 1'b0, 3'd0, 8'h00, 2'b10, 18, 0, 0, 1'b0);
        chk("p_rises", rise_cnt, 24);
        chk("p_cmd", int'(rxb[0]), 8'hC4);
        chk("p_b0", int'(rxb[1]), 8'hB1);
        chk("p_b1", int'(rxb[2]), 8'hB2);
        chk("p_rv", rv_cnt, 2);
        chk("p_rd0", int'(rvals[0]), 8'hD1);
        chk("p_rd1", int'(rvals[1]), 8'hD2);
        passthru = 2'b00;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
